// File: rtl/midi_uart_tx.sv
// MIDI OUT transmitter: fetches bytes from the FIFO read port and shifts them out as 8N1 frames.
// A one-byte holding register overlaps the next fetch with the current frame, so frames are gapless.
module midi_uart_tx #(
  parameter int pSysClkHz  = 50000000,
  parameter int pBaud      = 31250,
  parameter int pBitCycles = pSysClkHz / pBaud
) (
  input  logic       iCLK,
  input  logic       inARST,
  input  logic [7:0] iRd,
  input  logic       iRvd,
  input  logic       iEmp,
  output logic       oRe,
  input  logic       iTxEn,
  output logic       oTxd,
  output logic       oBusy,
  output logic [1:0] oState
);

  localparam int CW = (pBitCycles > 1) ? $clog2(pBitCycles) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(pBitCycles - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic [7:0]    hold;
  logic          hold_v;
  logic          pend;

  logic          fetch;
  logic          rd_take;
  logic          avail;
  logic          bit_end;
  logic          load;
  logic [7:0]    next_byte;

  // FIFO read handshake: a one-cycle oRe requests one byte and marks a fetch pending; the first
  // iRvd strobe while pending delivers that byte, any iRvd without a pending fetch is ignored.
  always_comb begin
    fetch     = iTxEn & ~iEmp & ~hold_v & ~pend;
    rd_take   = iRvd & pend;
    avail     = hold_v | rd_take;
    next_byte = hold_v ? hold : iRd;
    bit_end   = (cnt == LAST_CNT);
    load      = ((state == IDLE) || ((state == STOP) && bit_end)) && avail;
  end

  // Returning read data may bypass the holding register straight into the shifter.
  always_ff @(posedge iCLK or negedge inARST) begin
    if (!inARST) begin
      oRe    <= 1'b0;
      pend   <= 1'b0;
      hold   <= 8'h00;
      hold_v <= 1'b0;
    end else begin
      oRe <= fetch;
      if (fetch) begin
        pend <= 1'b1;
      end else if (rd_take) begin
        pend <= 1'b0;
      end
      if (load) begin
        hold_v <= 1'b0;
      end else if (rd_take) begin
        hold   <= iRd;
        hold_v <= 1'b1;
      end
    end
  end

  always_ff @(posedge iCLK or negedge inARST) begin
    if (!inARST) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= 3'd0;
      shift   <= 8'h00;
      oTxd    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          cnt  <= '0;
          oTxd <= 1'b1;
          if (load) begin
            shift <= next_byte;
            oTxd  <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (bit_end) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
            oTxd    <= shift[0];
            state   <= DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              oTxd  <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              oTxd    <= shift[1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (bit_end) begin
            cnt <= '0;
            if (load) begin
              shift <= next_byte;
              oTxd  <= 1'b0;
              state <= START;
            end else begin
              oTxd  <= 1'b1;
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge inARST) begin
    if (!inARST) begin
      oBusy <= 1'b0;
    end else begin
      oBusy <= (state != IDLE) | hold_v | pend;
    end
  end

  assign oState = state;

endmodule

// File: tb/tb_midi_uart_tx.sv
// Bench for midi_uart_tx: a queue-based FIFO model with programmable read latency feeds the DUT,
// and a line monitor rebuilds each expected 8N1 waveform from the pushed bytes.
module tb_midi_uart_tx;

  localparam int NB = 16;

  logic       iCLK = 1'b0;
  logic       inARST;
  logic [7:0] iRd;
  logic       iRvd;
  logic       iEmp;
  logic       oRe;
  logic       iTxEn;
  logic       oTxd;
  logic       oBusy;
  logic [1:0] oState;

  midi_uart_tx #(.pSysClkHz(500000), .pBaud(31250)) dut (
    .iCLK(iCLK), .inARST(inARST), .iRd(iRd), .iRvd(iRvd), .iEmp(iEmp), .oRe(oRe),
    .iTxEn(iTxEn), .oTxd(oTxd), .oBusy(oBusy), .oState(oState)
  );

  // clock / reset block
  always #5 iCLK = ~iCLK;
  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] fifo_q[$];
  logic [7:0] dat_q[$];
  int         due_q[$];
  int         start_q[$];
  int         lat = 1;
  bit         spur = 0;
  int         emp_fall_cyc = 0;
  int         last_start = 0;
  int         frames_done = 0;
  int         re_cnt = 0;
  int         re_double = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // FIFO read-side model: data appears with iRvd exactly lat cycles after oRe is seen
  initial begin
    iRvd = 1'b0;
    iRd  = 8'h00;
    iEmp = 1'b1;
    forever begin
      @(posedge iCLK);
      #1;
      iRvd = 1'b0;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        iRvd = 1'b1;
        iRd  = dat_q.pop_front();
        due_q.delete(0);
      end else if (spur) begin
        iRvd = 1'b1;
        iRd  = 8'hA5;
        spur = 0;
      end
      if (oRe === 1'b1 && fifo_q.size() > 0) begin
        due_q.push_back(cyc + lat);
        dat_q.push_back(fifo_q.pop_front());
      end
      if (iEmp && fifo_q.size() > 0) emp_fall_cyc = cyc;
      iEmp = (fifo_q.size() == 0);
    end
  end

  initial begin
    logic prev_re;
    prev_re = 1'b0;
    forever begin
      @(negedge iCLK);
      if (oRe === 1'b1) begin
        re_cnt++;
        if (prev_re) re_double++;
      end
      prev_re = (oRe === 1'b1);
    end
  end

  // line monitor: every frame must match start/data(LSB first)/stop of the next expected byte
  initial begin
    logic [7:0] b;
    logic       exp_bit;
    bit         have;
    bit         aborted;
    int         bad;
    forever begin
      @(negedge iCLK);
      if (inARST === 1'b1 && oTxd === 1'b0) begin
        start_q.push_back(cyc);
        last_start = cyc;
        have = (exp_q.size() > 0);
        b = have ? exp_q.pop_front() : 8'h00;
        bad = 0;
        aborted = 0;
        for (int k = 0; k < 10 * NB; k++) begin
          if (k > 0) @(negedge iCLK);
          if (inARST !== 1'b1) begin
            aborted = 1;
            break;
          end
          if (k < NB) exp_bit = 1'b0;
          else if (k >= 9 * NB) exp_bit = 1'b1;
          else exp_bit = b[k / NB - 1];
          if (oTxd !== exp_bit) bad++;
        end
        if (!aborted) begin
          chk("frame_expected", have, 1);
          chk("frame_bits", bad, 0);
          frames_done++;
        end else begin
          while (!(inARST === 1'b1 && oTxd === 1'b1)) @(negedge iCLK);
        end
      end
    end
  end

  // driver tasks
  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic wait_frames(input int target, input int budget);
    int t0;
    t0 = cyc;
    while (frames_done < target && cyc - t0 < budget) @(negedge iCLK);
    chk("frames_timeout", frames_done >= target, 1);
  endtask

  task automatic wait_start(input int budget);
    int t0;
    t0 = cyc;
    while (start_q.size() == 0 && cyc - t0 < budget) @(negedge iCLK);
    chk("start_timeout", start_q.size() > 0, 1);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge iCLK);
  endtask

  task automatic check_gaps(input int n, input string tag);
    chk({tag, "_count"}, start_q.size(), n);
    for (int i = 1; i < start_q.size(); i++)
      chk({tag, "_gap"}, start_q[i] - start_q[i-1], 10 * NB);
  endtask

  initial begin
    int r0;
    int f0;
    int s;
    int v_re;
    int v_txd;
    int v_busy;
    inARST = 1'b0;
    iTxEn  = 1'b1;
    repeat (3) @(negedge iCLK);
    chk("reset_txd", oTxd, 1);
    chk("reset_re", oRe, 0);
    chk("reset_busy", oBusy, 0);
    inARST = 1'b1;
    repeat (5) @(negedge iCLK);

    // single byte, latency 1
    lat = 1;
    r0 = re_cnt;
    f0 = frames_done;
    push(8'h90);
    wait_frames(f0 + 1, 400);
    chk("t1_latency", last_start - emp_fall_cyc, 3);
    chk("t1_re_pulses", re_cnt - r0, 1);
    wait_cyc(last_start + 10 * NB);
    chk("t1_busy_stop_end", oBusy, 1);
    @(negedge iCLK);
    chk("t1_busy_after", oBusy, 0);

    // three bytes queued together
    repeat (5) @(negedge iCLK);
    start_q.delete();
    r0 = re_cnt;
    f0 = frames_done;
    push(8'h90);
    push(8'h3C);
    push(8'h7F);
    wait_frames(f0 + 3, 700);
    chk("t2_re_pulses", re_cnt - r0, 3);
    check_gaps(3, "t2");

    // random burst with random read latency
    repeat (5) @(negedge iCLK);
    lat = $urandom_range(1, 40);
    start_q.delete();
    r0 = re_cnt;
    f0 = frames_done;
    for (int i = 0; i < 5; i++) push(8'($urandom_range(0, 255)));
    wait_frames(f0 + 5, 1200);
    chk("t2b_re_pulses", re_cnt - r0, 5);
    check_gaps(5, "t2b");

    // long idle with empty FIFO
    repeat (5) @(negedge iCLK);
    v_re = 0;
    v_txd = 0;
    v_busy = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge iCLK);
      if (oRe !== 1'b0) v_re++;
      if (oTxd !== 1'b1) v_txd++;
      if (oBusy !== 1'b0) v_busy++;
    end
    chk("t3_re_idle", v_re, 0);
    chk("t3_txd_idle", v_txd, 0);
    chk("t3_busy_idle", v_busy, 0);

    // drop transmit enable during data bit 3
    lat = 1;
    start_q.delete();
    r0 = re_cnt;
    f0 = frames_done;
    push(8'h3C);
    push(8'($urandom_range(0, 255)));
    push(8'($urandom_range(0, 255)));
    wait_start(100);
    s = start_q[0];
    wait_cyc(s + 4 * NB + 5);
    iTxEn = 1'b0;
    wait_frames(f0 + 2, 500);
    repeat (300) @(negedge iCLK);
    chk("t4_frames_disabled", frames_done - f0, 2);
    chk("t4_re_disabled", re_cnt - r0, 2);
    chk("t4_fifo_left", fifo_q.size(), 1);
    iTxEn = 1'b1;
    wait_frames(f0 + 3, 400);
    chk("t4_re_total", re_cnt - r0, 3);

    // spurious read strobe, then latency-3 start timing
    repeat (5) @(negedge iCLK);
    lat = 3;
    r0 = re_cnt;
    f0 = frames_done;
    spur = 1;
    repeat (50) @(negedge iCLK);
    chk("t5_spur_frames", frames_done - f0, 0);
    chk("t5_spur_busy", oBusy, 0);
    chk("t5_spur_txd", oTxd, 1);
    chk("t5_spur_re", re_cnt - r0, 0);
    push(8'($urandom_range(0, 255)));
    wait_frames(f0 + 1, 400);
    chk("t5_latency", last_start - emp_fall_cyc, 5);

    // reset during data bit 5
    repeat (5) @(negedge iCLK);
    lat = 1;
    start_q.delete();
    r0 = re_cnt;
    f0 = frames_done;
    push(8'h3C);
    push(8'h55);
    push(8'($urandom_range(0, 255)));
    wait_start(100);
    s = start_q[0];
    wait_cyc(s + 6 * NB + 3);
    inARST = 1'b0;
    #1;
    chk("t6_rst_txd", oTxd, 1);
    chk("t6_rst_re", oRe, 0);
    chk("t6_rst_busy", oBusy, 0);
    void'(exp_q.pop_front());
    chk("t6_fifo_left", fifo_q.size(), 1);
    repeat (3) @(negedge iCLK);
    inARST = 1'b1;
    wait_frames(f0 + 1, 400);
    chk("t6_re_total", re_cnt - r0, 3);

    repeat (5) @(negedge iCLK);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("re_single_cycle", re_double, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
